// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock through a
// ripple-borrow trial subtractor, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  // R never exceeds D-1 after a restore, so its top bit is always zero and only
  // WIDTH bits are stored; the shifted trial value r_shift keeps WIDTH+1 bits.
  logic [WIDTH-1:0] q_reg, d_reg, r_reg;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next, r_next;
  logic             accept, accept_zero, last_iter;

  // Trial subtraction r_shift - {0,D}; the top stage only propagates the borrow.
  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    diff    = '0;
    borrow  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = r_shift[i] ^ d_reg[i] ^ borrow;
      borrow  = (~r_shift[i] & d_reg[i]) | (~(r_shift[i] ^ d_reg[i]) & borrow);
    end
    no_borrow = ~(~r_shift[WIDTH] & borrow);
    q_next    = {q_reg[WIDTH-2:0], no_borrow};
    r_next    = no_borrow ? diff : r_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    last_iter   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            accept     = 1'b1;
            state_next = CALC;
          end else begin
            accept_zero = 1'b1;
            state_next  = DONE;
          end
        end
      end
      CALC: begin
        if (count == CNT_W'(WIDTH - 1)) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Result registers load straight from the final iteration's next values so
  // they are already valid in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        q_reg <= dividend;
        d_reg <= divisor;
        r_reg <= '0;
        count <= '0;
      end else if (state == CALC) begin
        q_reg <= q_next;
        r_reg <= r_next;
        count <= count + CNT_W'(1);
      end
      if (accept_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed cases plus
// random operands compared against plain integer division.
module tb_seq_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Runs one division, scrambling the inputs after acceptance, and checks
  // latency, busy duration, single-cycle done and results against the model.
  task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs, input bit check_inv);
    int edges;
    int busy_cycles;
    int exp_q, exp_r, exp_lat;
    exp_q   = (dvs == 0) ? 255 : int'(dvd) / int'(dvs);
    exp_r   = (dvs == 0) ? int'(dvd) : int'(dvd) % int'(dvs);
    exp_lat = (dvs == 0) ? 1 : WIDTH + 1;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    dividend    = 8'($urandom);
    divisor     = 8'($urandom);
    edges       = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
    end
    checkOutput("done_seen", 32'(done), 1);
    checkOutput("latency", edges, exp_lat);
    checkOutput("busy_cycles", busy_cycles, exp_lat);
    checkOutput("quotient", 32'(quotient), exp_q);
    checkOutput("remainder", 32'(remainder), exp_r);
    checkOutput("div_by_zero", 32'(div_by_zero), (dvs == 0) ? 1 : 0);
    if (check_inv && dvs != 0) begin
      checkOutput("inv_sum", int'(quotient) * int'(dvs) + int'(remainder), 32'(dvd));
      checkOutput("inv_rem_lt", 32'(remainder < dvs), 1);
    end
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 32'(done), 0);
    checkOutput("busy_idle", 32'(busy), 0);
  endtask

  // 200/13 with stray starts on cycle 3 and in the DONE cycle.
  task automatic ignoredStartTest();
    int pulses;
    int done_edge;
    bit done_last;
    pulses    = 0;
    done_edge = 0;
    done_last = 1'b0;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3 || done_last) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      done_last = done;
      if (done) begin
        pulses++;
        done_edge = k;
      end
    end
    checkOutput("ign_pulses", pulses, 1);
    checkOutput("ign_latency", done_edge, WIDTH + 1);
    checkOutput("ign_quotient", 32'(quotient), 15);
    checkOutput("ign_remainder", 32'(remainder), 5);
    checkOutput("ign_busy", 32'(busy), 0);
  endtask

  // Asynchronous reset mid-division must clear everything and suppress done.
  task automatic resetAbortTest();
    int pulses;
    pulses = 0;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_quotient", 32'(quotient), 0);
    checkOutput("rst_remainder", 32'(remainder), 0);
    checkOutput("rst_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("rst_no_done", pulses, 0);
    applyStimulus(8'd100, 8'd7, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_quotient", 32'(quotient), 0);
    checkOutput("reset_remainder", 32'(remainder), 0);
    checkOutput("reset_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;

    applyStimulus(8'd100, 8'd7, 1'b1);
    applyStimulus(8'd255, 8'd1, 1'b1);
    applyStimulus(8'd255, 8'd255, 1'b1);
    applyStimulus(8'd3, 8'd10, 1'b1);
    applyStimulus(8'd0, 8'd9, 1'b1);
    applyStimulus(8'd5, 8'd0, 1'b0);
    applyStimulus(8'd20, 8'd4, 1'b1);
    ignoredStartTest();
    resetAbortTest();

    for (int n = 0; n < 1000; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
